// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, well-known register indices and read-port type for the KGP-RISC register file.
package regfile_pkg;
    localparam int DFLT_DATA_W = 32;
    localparam int DFLT_ADDR_W = 5;
    localparam int REG_ZERO    = 0;
    localparam int REG_RA      = 31;

    typedef struct packed {
        logic [DFLT_DATA_W-1:0] data;
        logic                   busy;
    } rd_port_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with zero-register handling, write/link bypass and busy qualification.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DFLT_DATA_W,
    parameter int ADDR_W   = DFLT_ADDR_W,
    parameter int LINK_REG = REG_RA,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);
    logic is_zero, hit_wr, hit_link;

    always_comb begin
        is_zero  = rd_addr == ADDR_W'(REG_ZERO);
        hit_wr   = wr_en && wr_addr == rd_addr;
        hit_link = link_en && rd_addr == ADDR_W'(LINK_REG);
        rd_data  = is_zero              ? '0 :
                   (BYPASS && hit_wr)   ? wr_data :
                   (BYPASS && hit_link) ? link_data : mem[rd_addr];
        // a releasing writeback clears the busy view in the same cycle regardless of BYPASS
        rd_busy  = !is_zero && busy[rd_addr] && !hit_wr;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with per-register busy scoreboard, link port and write bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DFLT_DATA_W,
    parameter int ADDR_W   = DFLT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = REG_RA,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    output logic [NUM_RD-1:0]        rdBusy,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic                     linkEn,
    input  logic [DATA_W-1:0]        linkData,
    input  logic                     rsvEn,
    input  logic [ADDR_W-1:0]        rsvAddr,
    output logic                     rsvOk,
    output logic [ADDR_W:0]          busyCnt
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [1:DEPTH-1];
    logic [DATA_W-1:0] mem_d [1:DEPTH-1];
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:1]  busy_q, busy_d;
    logic [DEPTH-1:0]  busy_vec;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              set, clr;

    always_comb begin
        rf[0]    = '0;
        busy_vec = {busy_q, 1'b0};
        for (int i = 1; i < DEPTH; i++) rf[i] = mem_q[i];
    end

    // register 0 has no storage; the writeback port beats the link port on LINK_REG
    always_comb begin
        for (int i = 1; i < DEPTH; i++)
            mem_d[i] = (wrEn && wrAddr == ADDR_W'(i)) ? wrData :
                       (linkEn && i == LINK_REG)      ? linkData : mem_q[i];
    end

    always_comb begin
        rsvOk = rsvEn && (rsvAddr == ADDR_W'(REG_ZERO) || !busy_vec[rsvAddr] || (wrEn && wrAddr == rsvAddr));
        set   = rsvOk && rsvAddr != ADDR_W'(REG_ZERO);
        clr   = wrEn && busy_vec[wrAddr];
        // set is applied after clear so a same-cycle re-reservation keeps the bit
        for (int i = 1; i < DEPTH; i++)
            busy_d[i] = (set && rsvAddr == ADDR_W'(i)) || (busy_q[i] && !(wrEn && wrAddr == ADDR_W'(i)));
        cnt_d = cnt_q + (ADDR_W+1)'(set) - (ADDR_W+1)'(clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busyCnt = cnt_q;

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            rf_read_port #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .LINK_REG(LINK_REG),
                .BYPASS  (BYPASS)
            ) u_rd (
                .rd_addr  (rdAddr[p*ADDR_W +: ADDR_W]),
                .mem      (rf),
                .busy     (busy_vec),
                .wr_en    (wrEn),
                .wr_addr  (wrAddr),
                .wr_data  (wrData),
                .link_en  (linkEn),
                .link_data(linkData),
                .rd_data  (rdData[p*DATA_W +: DATA_W]),
                .rd_busy  (rdBusy[p])
            );
        end
    endgenerate
endmodule
